// File: rtl/pipe_pkg.sv
// Types and constants shared by the elastic pipeline stages of the core.
package pipe_pkg;

  localparam int IF_PAYLOAD_W = 64;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pipe_state_t;

  function automatic logic [1:0] occ_of(input pipe_state_t s);
    case (s)
      PS_ONE:  occ_of = 2'd1;
      PS_TWO:  occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for per-stage performance events.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline register with a 2-entry skid buffer, flush and stall counting.
// Both handshake outputs are registered; the skid slot absorbs the one-cycle ready lag.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = IF_PAYLOAD_W,
  parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              out_valid_q, in_ready_q;
  logic [1:0]        occ_q;
  logic              in_fire, out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Anything accepted this cycle is squashed along with the held entries.
      state_d = PS_EMPTY;
      main_d  = FLUSH_VAL;
      skid_d  = FLUSH_VAL;
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (in_fire) begin
            state_d = PS_ONE;
            main_d  = in_data;
          end
        end
        PS_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (out_fire) begin
            state_d = PS_EMPTY;
          end else if (in_fire) begin
            state_d = PS_TWO;
            skid_d  = in_data;
          end
        end
        PS_TWO: begin
          if (out_fire) begin
            state_d = PS_ONE;
            main_d  = skid_q;
            skid_d  = FLUSH_VAL;
          end
        end
        default: state_d = PS_EMPTY;
      endcase
    end
  end

  // Status outputs are registered copies decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PS_EMPTY;
      main_q      <= FLUSH_VAL;
      skid_q      <= FLUSH_VAL;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= (state_d != PS_EMPTY);
      in_ready_q  <= (state_d != PS_TWO);
      occ_q       <= occ_of(state_d);
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid_q & ~out_ready),
    .count (stall_cnt)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and scoreboarded checks of pipe_skid_stage handshake, flush, stall counter and reset.
module tb_pipe_skid_stage;

  localparam int          DW = 16;
  localparam int          CW = 4;
  localparam logic [15:0] FV = 16'hF1F0;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  pipe_skid_stage #(.DATA_W(DW), .FLUSH_VAL(FV), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] sb[$];
    logic [DW-1:0] exp_d;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_occ", occupancy, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_out_data", out_data, FV);
    rst = 1'b0;

    // 1: full-rate stream
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = DW'(i);
      step();
      chk("stream_valid", out_valid, 1);
      chk("stream_data", out_data, i);
      chk("stream_occ", occupancy, 1);
      chk("stream_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain_valid", out_valid, 0);
    chk("stream_stall", stall_cnt, 0);

    // 2: backpressure fills the skid slot
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h000A;
    step();
    chk("bp_A_data", out_data, 16'h000A);
    chk("bp_A_in_ready", in_ready, 1);
    chk("bp_A_occ", occupancy, 1);
    in_data = 16'h000B;
    step();
    chk("bp_B_in_ready", in_ready, 0);
    chk("bp_B_occ", occupancy, 2);
    chk("bp_B_stall", stall_cnt, 1);
    in_data = 16'h000C;
    step();
    chk("bp_hold_data", out_data, 16'h000A);
    chk("bp_hold_occ", occupancy, 2);
    chk("bp_hold_stall", stall_cnt, 2);
    out_ready = 1'b1;
    step();
    chk("bp_rel_B", out_data, 16'h000B);
    chk("bp_rel_in_ready", in_ready, 1);
    chk("bp_rel_occ", occupancy, 1);
    step();
    chk("bp_rel_C", out_data, 16'h000C);
    chk("bp_rel_C_valid", out_valid, 1);
    in_valid = 1'b0;
    step();
    chk("bp_empty", out_valid, 0);
    chk("bp_stall_final", stall_cnt, 2);

    // 3: flush while full, concurrent input discarded
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0011;
    step();
    in_data = 16'h0022;
    step();
    chk("fl_pre_occ", occupancy, 2);
    in_data = 16'h00DD; flush = 1'b1;
    step();
    chk("fl_valid", out_valid, 0);
    chk("fl_occ", occupancy, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_data", out_data, FV);
    chk("fl_stall", stall_cnt, 4);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl_no_D", out_valid, 0);
    end

    // 4: stall counter saturation survives flush
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0033;
    step();
    chk("sat_start", stall_cnt, 4);
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("sat_15", stall_cnt, 15);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("sat_after_flush", stall_cnt, 15);
    chk("sat_flush_valid", out_valid, 0);

    // 5: async reset mid-cycle while full
    in_valid = 1'b1; in_data = 16'h0044;
    step();
    in_data = 16'h0045;
    step();
    chk("ar_pre_occ", occupancy, 2);
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_in_ready", in_ready, 1);
    chk("ar_occ", occupancy, 0);
    chk("ar_stall", stall_cnt, 0);
    chk("ar_data", out_data, FV);
    step();
    rst = 1'b0;
    in_valid = 1'b1; in_data = 16'h0055; out_ready = 1'b1;
    step();
    chk("ar_new_valid", out_valid, 1);
    chk("ar_new_data", out_data, 16'h0055);
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;

    // 6: random valid/ready against an in-order scoreboard
    in_valid = 1'b0; out_ready = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (!(in_valid && !in_ready)) begin
        in_valid = $urandom_range(0, 3) != 0;
        in_data  = DW'($urandom);
      end
      out_ready = $urandom_range(0, 2) != 0;
      if (out_valid && out_ready) begin
        exp_d = (sb.size() > 0) ? sb.pop_front() : ~out_data;
        chk("rnd_data", out_data, exp_d);
      end
      if (in_valid && in_ready) sb.push_back(in_data);
      step();
      chk("rnd_occ", occupancy, sb.size());
      chk("rnd_valid", out_valid, sb.size() != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
